// File: rtl/lc3b_dcache.sv
// lc3b_dcache: direct-mapped write-back write-allocate data cache, 8 sets x 128-bit lines
module lc3b_dcache (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_wmask,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state;
  logic [127:0] data [8];
  logic [8:0] tag [8];
  logic [7:0] valid, dirty;
  logic [2:0] idx, word;
  logic [127:0] line;
  logic hit, req, unused_bit;
  assign idx = mem_address[6:4];
  assign word = mem_address[3:1];
  assign unused_bit = mem_address[0];
  assign line = data[idx];
  assign hit = valid[idx] && tag[idx] == mem_address[15:7];
  assign req = mem_read | mem_write;
  assign mem_resp = state == IDLE && req && hit;
  assign mem_rdata = line[{word, 4'd0} +: 16];
  assign pmem_read = state == FILL;
  assign pmem_write = state == WRITEBACK;
  assign pmem_address = state == WRITEBACK ? {tag[idx], idx, 4'd0} : {mem_address[15:4], 4'd0};
  assign pmem_wdata = line;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_resp && mem_write) dirty[idx] <= 1'b1;
          else if (req && !hit) state <= dirty[idx] ? WRITEBACK : FILL;
        end
        WRITEBACK: if (pmem_resp) begin
          dirty[idx] <= 1'b0;
          state <= FILL;
        end
        FILL: if (pmem_resp) begin
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // line storage carries no reset; validity alone decides whether it is meaningful
  always_ff @(posedge clk) begin
    if (rst_n && state == FILL && pmem_resp) begin
      data[idx] <= pmem_rdata;
      tag[idx] <= mem_address[15:7];
    end else if (rst_n && mem_resp && mem_write) begin
      if (mem_wmask[0]) data[idx][{word, 4'd0} +: 8] <= mem_wdata[7:0];
      if (mem_wmask[1]) data[idx][{word, 4'd8} +: 8] <= mem_wdata[15:8];
    end
  end
endmodule

// File: tb/tb_lc3b_dcache.sv
// tb_lc3b_dcache: directed scoreboard bench for lc3b_dcache with a 3-cycle pmem model
module tb_lc3b_dcache;
  logic clk = 1'b0, rst_n;
  logic [15:0] mem_address, mem_wdata, mem_rdata, pmem_address;
  logic mem_read, mem_write, mem_resp, pmem_read, pmem_write, pmem_resp;
  logic [1:0] mem_wmask;
  logic [127:0] pmem_wdata, pmem_rdata;
  typedef struct {logic [15:0] rdata; int cyc; logic rd;} exp_t;
  typedef struct {logic w; logic [15:0] a; logic [127:0] d;} op_t;
  exp_t sb[$];
  op_t obs_ops[$], exp_ops[$];
  logic [127:0] pm [logic [15:0]];
  int vectors = 0, misses = 0, cnt = 0;
  localparam logic [127:0] L0080 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [127:0] L0080W = 128'h7777_6666_5555_4444_3333_2222_AB11_0000;
  localparam logic [127:0] L0480 = 128'h4877_4866_4855_4844_4833_4822_4811_4800;
  localparam logic [127:0] L0090 = 128'h9077_9066_9055_9044_9033_9022_9011_9000;
  localparam logic [127:0] L0490 = 128'hC977_C966_C955_C944_C933_C922_C911_C900;

  lc3b_dcache dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // physical memory answers each strobe on its third cycle and logs the transfer
  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        cnt = 0;
      end
      if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == 3) begin
          pmem_resp = 1'b1;
          if (pmem_write) begin
            pm[pmem_address] = pmem_wdata;
            obs_ops.push_back('{1'b1, pmem_address, pmem_wdata});
          end else begin
            pmem_rdata = pm[pmem_address];
            obs_ops.push_back('{1'b0, pmem_address, pmem_rdata});
          end
        end
      end else cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    assert (got === exp) else begin
      misses++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic check_ops(input string tag);
    op_t o, e;
    chk({tag, "_op_count"}, 128'(obs_ops.size()), 128'(exp_ops.size()));
    while (obs_ops.size() > 0 && exp_ops.size() > 0) begin
      o = obs_ops.pop_front();
      e = exp_ops.pop_front();
      chk({tag, "_op_kind"}, 128'(o.w), 128'(e.w));
      chk({tag, "_op_addr"}, 128'(o.a), 128'(e.a));
      if (e.w) chk({tag, "_op_wdata"}, o.d, e.d);
    end
    obs_ops.delete();
    exp_ops.delete();
  endtask

  // called just after a falling edge; holds the request until mem_resp and counts cycles 1-based
  task automatic access(input string tag, input logic [15:0] a, input logic wr, input logic [1:0] m,
                        input logic [15:0] wd, input logic [15:0] er, input int ec);
    exp_t e;
    int cyc;
    sb.push_back('{er, ec, !wr});
    mem_address = a;
    mem_read = !wr;
    mem_write = wr;
    mem_wmask = m;
    mem_wdata = wd;
    for (cyc = 1; cyc <= 40; cyc++) begin
      #2;
      if (mem_resp) break;
      @(negedge clk);
    end
    e = sb.pop_front();
    chk({tag, "_cycles"}, 128'(cyc), 128'(e.cyc));
    if (e.rd) chk({tag, "_rdata"}, 128'(mem_rdata), 128'(e.rdata));
    @(negedge clk);
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    pm[16'h0080] = L0080;
    pm[16'h0480] = L0480;
    pm[16'h0090] = L0090;
    pm[16'h0490] = L0490;
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_wmask = 2'b00;
    mem_wdata = '0;
    mem_address = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_resp", 128'(mem_resp), 128'(0));
    chk("rst_pread", 128'(pmem_read), 128'(0));
    chk("rst_pwrite", 128'(pmem_write), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_ops.push_back('{1'b0, 16'h0080, '0});
    access("cold_rd", 16'h0082, 1'b0, 2'b00, 16'h0, 16'h1111, 5);
    check_ops("cold_rd");
    access("hit_rd", 16'h008E, 1'b0, 2'b00, 16'h0, 16'h7777, 1);
    check_ops("hit_rd");
    access("wr_hit", 16'h0082, 1'b1, 2'b10, 16'hABCD, 16'h0, 1);
    check_ops("wr_hit");
    access("rd_merge", 16'h0082, 1'b0, 2'b00, 16'h0, 16'hAB11, 1);
    exp_ops.push_back('{1'b1, 16'h0080, L0080W});
    exp_ops.push_back('{1'b0, 16'h0480, '0});
    access("dirty_ev", 16'h0482, 1'b0, 2'b00, 16'h0, 16'h4811, 8);
    check_ops("dirty_ev");
    exp_ops.push_back('{1'b0, 16'h0080, '0});
    access("clean_ev", 16'h0082, 1'b0, 2'b00, 16'h0, 16'hAB11, 5);
    check_ops("clean_ev");
    mem_address = 16'h0090;
    mem_read = 1'b1;
    @(negedge clk);
    #2;
    chk("fill_pread", 128'(pmem_read), 128'(1));
    chk("fill_addr", 128'(pmem_address), 128'(16'h0090));
    @(negedge clk);
    rst_n = 1'b0;
    mem_read = 1'b0;
    @(negedge clk);
    #2;
    chk("abort_pread", 128'(pmem_read), 128'(0));
    chk("abort_pwrite", 128'(pmem_write), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_ops("abort");
    exp_ops.push_back('{1'b0, 16'h0080, '0});
    access("inval_rd", 16'h0082, 1'b0, 2'b00, 16'h0, 16'hAB11, 5);
    check_ops("inval_rd");
    exp_ops.push_back('{1'b0, 16'h0090, '0});
    access("refill", 16'h0090, 1'b0, 2'b00, 16'h0, 16'h9000, 5);
    check_ops("refill");
    access("mask00", 16'h0090, 1'b1, 2'b00, 16'hFFFF, 16'h0, 1);
    check_ops("mask00");
    exp_ops.push_back('{1'b1, 16'h0090, L0090});
    exp_ops.push_back('{1'b0, 16'h0490, '0});
    access("mask00_ev", 16'h0490, 1'b0, 2'b00, 16'h0, 16'hC900, 8);
    check_ops("mask00_ev");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end
endmodule
